// File: rtl/spi_pkg.sv
// Shared types and constants for the single chip-select SPI master.
// Used by spi_clk_gen and spi_master_cs.
package spi_pkg;

    localparam int BITS_PER_BYTE  = 8;
    localparam int EDGES_PER_BYTE = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT_BYTE,
        CS_HOLD,
        CS_INACTIVE
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI_Clk generator: emits 16 edges per byte, one every CLKS_PER_HALF_BIT cycles, while enabled.
// Edge strobes fire in the cycle before SPI_Clk toggles so the master acts on the same clock edge.
module spi_clk_gen #(
    parameter int CLKS_PER_HALF_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic cpol_i,
    output logic spi_clk_o,
    output logic leading_edge_o,
    output logic trailing_edge_o,
    output logic edges_done_o
);
    import spi_pkg::*;

    localparam int HALF_W = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);
    localparam int EDGE_W = $clog2(EDGES_PER_BYTE + 1);

    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              spi_clk_q, spi_clk_d;
    logic              strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            spi_clk_q  <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            spi_clk_q  <= spi_clk_d;
        end
    end

    // While disabled the clock parks at the polarity the master will use next.
    always_comb begin
        half_cnt_d = half_cnt_q;
        edge_cnt_d = edge_cnt_q;
        spi_clk_d  = spi_clk_q;
        strobe     = enable_i && (half_cnt_q == HALF_LAST)
                     && (edge_cnt_q < EDGE_W'(EDGES_PER_BYTE));
        if (!enable_i) begin
            half_cnt_d = '0;
            edge_cnt_d = '0;
            spi_clk_d  = cpol_i;
        end else if (strobe) begin
            half_cnt_d = '0;
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
            spi_clk_d  = ~spi_clk_q;
        end else if (half_cnt_q != HALF_LAST) begin
            half_cnt_d = half_cnt_q + HALF_W'(1);
        end
    end

    assign spi_clk_o       = spi_clk_q;
    assign leading_edge_o  = strobe && !edge_cnt_q[0];
    assign trailing_edge_o = strobe && edge_cnt_q[0];
    assign edges_done_o    = strobe && (edge_cnt_q == EDGE_W'(EDGES_PER_BYTE - 1));

endmodule

// File: rtl/spi_master_cs.sv
// SPI master with one chip select: frames of TX_Count bytes under CS_n low, then a CS-high gap.
// Define SPI_MASTER_LOOPBACK_EN to sample the internal MOSI register instead of SPI_MISO_i.
module spi_master_cs #(
    parameter int CLKS_PER_HALF_BIT = 10,
    parameter int CS_INACTIVE_CLKS  = 10,
    parameter int MAX_BYTES_PER_CS  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] TX_Count_i,
    input  logic [7:0]                            TX_Byte_i,
    input  logic                                  TX_DV_i,
    input  logic                                  CPOL_i,
    input  logic                                  CPHA_i,
    output logic                                  TX_Ready_o,
    output logic                                  RX_DV_o,
    output logic [7:0]                            RX_Byte_o,
    output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] RX_Count_o,
    output logic                                  SPI_Clk_o,
    output logic                                  SPI_MOSI_o,
    input  logic                                  SPI_MISO_i,
    output logic                                  SPI_CS_n_o
);
    import spi_pkg::*;

    localparam int CNT_W   = $clog2(MAX_BYTES_PER_CS + 1);
    localparam int INACT_W = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [INACT_W-1:0] INACT_LAST = INACT_W'(CS_INACTIVE_CLKS - 1);

    spi_state_t               state_q, state_d;
    spi_mode_t                mode_q, mode_d;
    logic [CNT_W-1:0]         frame_len_q, frame_len_d;
    logic [CNT_W-1:0]         rx_count_q, rx_count_d;
    logic [BITS_PER_BYTE-1:0] tx_shift_q, tx_shift_d;
    logic [BITS_PER_BYTE-1:0] rx_shift_q, rx_shift_d;
    logic [BITS_PER_BYTE-1:0] rx_byte_q, rx_byte_d;
    logic                     rx_dv_q, rx_dv_d;
    logic                     mosi_q, mosi_d;
    logic                     cs_n_q, cs_n_d;
    logic                     tx_ready_q, tx_ready_d;
    logic [INACT_W-1:0]       inact_cnt_q, inact_cnt_d;

    logic                     clk_en, clk_cpol;
    logic                     leading_edge, trailing_edge, edges_done;
    logic                     miso_bit, sample_edge, shift_edge;
    logic                     load, load_cpha;
    logic [BITS_PER_BYTE-1:0] load_byte;
    logic [CNT_W-1:0]         eff_count, rx_count_inc;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = SPI_MISO_i;
    assign miso_bit    = mosi_q;
`else
    assign miso_bit    = SPI_MISO_i;
`endif

    // A new frame's CPOL must reach SPI_Clk on the same edge CS_n falls.
    assign clk_en   = (state_q == SHIFT);
    assign clk_cpol = (state_q == IDLE && TX_DV_i) ? CPOL_i : mode_q.cpol;

    spi_clk_gen #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_clk_gen (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (clk_en),
        .cpol_i         (clk_cpol),
        .spi_clk_o      (SPI_Clk_o),
        .leading_edge_o (leading_edge),
        .trailing_edge_o(trailing_edge),
        .edges_done_o   (edges_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            frame_len_q <= '0;
            rx_count_q  <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            tx_ready_q  <= 1'b1;
            inact_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            frame_len_q <= frame_len_d;
            rx_count_q  <= rx_count_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            tx_ready_q  <= tx_ready_d;
            inact_cnt_q <= inact_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        frame_len_d  = frame_len_q;
        rx_count_d   = rx_count_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        rx_dv_d      = 1'b0;
        mosi_d       = mosi_q;
        inact_cnt_d  = inact_cnt_q;
        load         = 1'b0;
        load_cpha    = mode_q.cpha;
        load_byte    = TX_Byte_i;
        rx_count_inc = rx_count_q + CNT_W'(1);
        sample_edge  = mode_q.cpha ? trailing_edge : leading_edge;
        shift_edge   = mode_q.cpha ? leading_edge : (trailing_edge && !edges_done);

        if (TX_Count_i == '0)
            eff_count = CNT_W'(1);
        else if (TX_Count_i > CNT_W'(MAX_BYTES_PER_CS))
            eff_count = CNT_W'(MAX_BYTES_PER_CS);
        else
            eff_count = TX_Count_i;

        case (state_q)
            IDLE: begin
                if (TX_DV_i) begin
                    mode_d      = '{cpol: CPOL_i, cpha: CPHA_i};
                    frame_len_d = eff_count;
                    rx_count_d  = '0;
                    load        = 1'b1;
                    load_cpha   = CPHA_i;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (sample_edge)
                    rx_shift_d = {rx_shift_q[BITS_PER_BYTE-2:0], miso_bit};
                if (shift_edge) begin
                    mosi_d     = tx_shift_q[BITS_PER_BYTE-1];
                    tx_shift_d = {tx_shift_q[BITS_PER_BYTE-2:0], 1'b0};
                end
                // With CPHA=1 the final sample coincides with the 16th edge.
                if (edges_done) begin
                    rx_byte_d  = mode_q.cpha ? {rx_shift_q[BITS_PER_BYTE-2:0], miso_bit}
                                             : rx_shift_q;
                    rx_dv_d    = 1'b1;
                    rx_count_d = rx_count_inc;
                    state_d    = (rx_count_inc < frame_len_q) ? WAIT_BYTE : CS_HOLD;
                end
            end
            WAIT_BYTE: begin
                if (TX_DV_i) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            CS_HOLD: begin
                inact_cnt_d = '0;
                state_d     = CS_INACTIVE;
            end
            CS_INACTIVE: begin
                if (inact_cnt_q == INACT_LAST)
                    state_d = IDLE;
                else
                    inact_cnt_d = inact_cnt_q + INACT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // CPHA=0 presents bit 7 before the first edge; CPHA=1 shifts it out on the first leading edge.
        if (load) begin
            if (load_cpha) begin
                tx_shift_d = load_byte;
            end else begin
                mosi_d     = load_byte[BITS_PER_BYTE-1];
                tx_shift_d = {load_byte[BITS_PER_BYTE-2:0], 1'b0};
            end
        end

        cs_n_d     = (state_d == IDLE) || (state_d == CS_INACTIVE);
        tx_ready_d = (state_d == IDLE) || (state_d == WAIT_BYTE);
    end

    assign TX_Ready_o = tx_ready_q;
    assign RX_DV_o    = rx_dv_q;
    assign RX_Byte_o  = rx_byte_q;
    assign RX_Count_o = rx_count_q;
    assign SPI_MOSI_o = mosi_q;
    assign SPI_CS_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_master_cs.sv
// Scoreboard bench for spi_master_cs: random frames against a behavioural SPI slave and frame model.
// Honours SPI_MASTER_LOOPBACK_EN by expecting each received byte to echo the transmitted one.
module tb_spi_master_cs;

    localparam int HALF    = 2;
    localparam int INACT   = 5;
    localparam int MAXB    = 8;
    localparam int CW      = $clog2(MAXB + 1);
    localparam int TIMEOUT = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] TX_Count = '0;
    logic [7:0]    TX_Byte = '0;
    logic          TX_DV = 1'b0, CPOL = 1'b0, CPHA = 1'b0;
    logic          TX_Ready, RX_DV, SPI_Clk, SPI_MOSI, SPI_CS_n;
    logic [7:0]    RX_Byte;
    logic [CW-1:0] RX_Count;
    logic          SPI_MISO = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit monOn  = 0;
    logic curCpol = 1'b0, curCpha = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] count;
    } rx_exp_t;

    rx_exp_t    rxQ[$];
    logic [7:0] mosiQ[$];
    logic       misoBits[$];
    logic [7:0] txBuf[MAXB];
    logic [7:0] rplBuf[MAXB];

    spi_master_cs #(
        .CLKS_PER_HALF_BIT(HALF),
        .CS_INACTIVE_CLKS (INACT),
        .MAX_BYTES_PER_CS (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .TX_Count_i(TX_Count),
        .TX_Byte_i (TX_Byte),
        .TX_DV_i   (TX_DV),
        .CPOL_i    (CPOL),
        .CPHA_i    (CPHA),
        .TX_Ready_o(TX_Ready),
        .RX_DV_o   (RX_DV),
        .RX_Byte_o (RX_Byte),
        .RX_Count_o(RX_Count),
        .SPI_Clk_o (SPI_Clk),
        .SPI_MOSI_o(SPI_MOSI),
        .SPI_MISO_i(SPI_MISO),
        .SPI_CS_n_o(SPI_CS_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Slave-side MISO driver: next bit of the frame's reply stream.
    task automatic driveMiso();
`ifdef SPI_MASTER_LOOPBACK_EN
        SPI_MISO = 1'b1;
`else
        SPI_MISO = (misoBits.size() != 0) ? misoBits.pop_front() : 1'b0;
`endif
    endtask

    // Monitor: behavioural slave plus scoreboard and frame-timing checks.
    logic prevClk = 1'b0, prevCsn = 1'b1, prevRdy = 1'b1;
    int   tRdyFall = 0, tRxDv = 0, tCsRise = 0, capBits = 0;
    logic [7:0] capByte = '0;
    logic [7:0] lastCount = '0;

    always @(negedge clk) begin
        logic csFall, csRise, inFrame, lead, trail;
        rx_exp_t e;
        csFall  = prevCsn && !SPI_CS_n;
        csRise  = !prevCsn && SPI_CS_n;
        inFrame = !prevCsn && !SPI_CS_n;
        lead    = inFrame && (prevClk == curCpol) && (SPI_Clk != curCpol);
        trail   = inFrame && (prevClk != curCpol) && (SPI_Clk == curCpol);
        if (monOn && !rst) begin
            if (csFall) begin
                checkOutput("rx_count_clear", 32'(RX_Count), 32'd0);
                checkOutput("sclk_start_cpol", 32'(SPI_Clk), 32'(curCpol));
                capBits = 0;
                if (!curCpha) driveMiso();
            end
            if (curCpha ? trail : lead) begin
                capByte = {capByte[6:0], SPI_MOSI};
                capBits++;
                if (capBits == 8) begin
                    capBits = 0;
                    if (mosiQ.size() == 0) failNow("mosi_unexpected_byte");
                    else checkOutput("mosi_byte", 32'(capByte), 32'(mosiQ.pop_front()));
                end
            end
            if (curCpha ? lead : trail) driveMiso();
            if (prevRdy && !TX_Ready) tRdyFall = cyc;
            if (RX_DV === 1'b1) begin
                if (rxQ.size() == 0) begin
                    failNow("rx_unexpected_dv");
                end else begin
                    e = rxQ.pop_front();
                    checkOutput("rx_byte", 32'(RX_Byte), 32'(e.data));
                    checkOutput("rx_count", 32'(RX_Count), 32'(e.count));
                    lastCount = e.count;
                end
                checkOutput("byte_time", 32'(cyc - tRdyFall), 32'(16 * HALF));
                checkOutput("sclk_idle_after_byte", 32'(SPI_Clk), 32'(curCpol));
                tRxDv = cyc;
            end
            if (csRise) begin
                checkOutput("cs_hold", 32'(cyc - tRxDv), 32'd1);
                checkOutput("sclk_idle_cs_high", 32'(SPI_Clk), 32'(curCpol));
                tCsRise = cyc;
            end
            if (!prevRdy && TX_Ready && SPI_CS_n) begin
                checkOutput("cs_gap", 32'(cyc - tCsRise), 32'(INACT));
                checkOutput("rx_count_held", 32'(RX_Count), 32'(lastCount));
            end
        end
        prevClk = SPI_Clk;
        prevCsn = SPI_CS_n;
        prevRdy = TX_Ready;
    end

    // Waits for TX_Ready, pulsing stray TX_DV while it is low (must be ignored).
    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (TX_Ready === 1'b1) begin
                TX_DV = 1'b0;
                ok = 1'b1;
                return;
            end
            TX_DV   = ($urandom_range(0, 5) == 0);
            TX_Byte = 8'($urandom);
            @(posedge clk);
            #1;
        end
        TX_DV = 1'b0;
        failNow("tx_ready_timeout");
    endtask

    // Issues one frame from txBuf/rplBuf and queues the expected slave/master view of it.
    task automatic applyStimulus(input int raw, input logic pol, input logic pha);
        int eff;
        bit ok;
        rx_exp_t e;
        eff = (raw == 0) ? 1 : (raw > MAXB) ? MAXB : raw;
        waitReady(ok);
        if (!ok) return;
        curCpol = pol;
        curCpha = pha;
        for (int k = 0; k < eff; k++) begin
            mosiQ.push_back(txBuf[k]);
`ifdef SPI_MASTER_LOOPBACK_EN
            e.data = txBuf[k];
`else
            e.data = rplBuf[k];
`endif
            e.count = 8'(k + 1);
            rxQ.push_back(e);
            for (int b = 7; b >= 0; b--) misoBits.push_back(rplBuf[k][b]);
        end
        for (int k = 0; k < eff; k++) begin
            if (k > 0) begin
                waitReady(ok);
                if (!ok) return;
            end
            TX_Byte  = txBuf[k];
            TX_Count = (k == 0) ? CW'(raw) : CW'($urandom);
            CPOL     = (k == 0) ? pol : 1'($urandom);
            CPHA     = (k == 0) ? pha : 1'($urandom);
            TX_DV    = 1'b1;
            @(posedge clk);
            #1;
            TX_DV   = 1'b0;
            TX_Byte = 8'($urandom);
        end
    endtask

    initial begin
        bit ok;
        int edges;
        logic lastClk;
        logic [7:0] readTx[MAXB];
        logic [7:0] readRx[MAXB];
        readTx = '{8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        readRx = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx_ready", 32'(TX_Ready), 32'd1);
        checkOutput("reset_rx_dv", 32'(RX_DV), 32'd0);
        checkOutput("reset_rx_byte", 32'(RX_Byte), 32'd0);
        checkOutput("reset_rx_count", 32'(RX_Count), 32'd0);
        checkOutput("reset_sclk", 32'(SPI_Clk), 32'd0);
        checkOutput("reset_mosi", 32'(SPI_MOSI), 32'd0);
        checkOutput("reset_cs_n", 32'(SPI_CS_n), 32'd1);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        monOn = 1;

        // Mode 0 write frame.
        txBuf[0] = 8'h0A; txBuf[1] = 8'h2D; txBuf[2] = 8'h02;
        for (int k = 0; k < MAXB; k++) rplBuf[k] = 8'($urandom);
        applyStimulus(3, 1'b0, 1'b0);

        // Eight-byte read frame.
        for (int k = 0; k < MAXB; k++) begin
            txBuf[k]  = readTx[k];
            rplBuf[k] = readRx[k];
        end
        applyStimulus(8, 1'b0, 1'b0);

        // Mode 3 single byte.
        txBuf[0] = 8'hA5; rplBuf[0] = 8'h3C;
        applyStimulus(1, 1'b1, 1'b1);

        // Count clamping: 0 acts as 1, above max acts as max.
        for (int k = 0; k < MAXB; k++) begin
            txBuf[k]  = 8'($urandom);
            rplBuf[k] = 8'($urandom);
        end
        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(12, 1'b1, 1'b0);

        // Loopback pattern (also a plain two-byte frame when loopback is off).
        txBuf[0] = 8'h5A; txBuf[1] = 8'hC3;
        rplBuf[0] = 8'($urandom); rplBuf[1] = 8'($urandom);
        applyStimulus(2, 1'b0, 1'b0);

        // Asynchronous reset at the 7th SPI_Clk edge of byte 2.
        waitReady(ok);
        monOn = 0;
        curCpol = 1'b1;
        curCpha = 1'b1;
        TX_Count = CW'(2); TX_Byte = 8'h81; CPOL = 1'b1; CPHA = 1'b1; TX_DV = 1'b1;
        @(posedge clk);
        #1;
        TX_DV = 1'b0;
        waitReady(ok);
        TX_Byte = 8'h7E; TX_DV = 1'b1;
        @(posedge clk);
        #1;
        TX_DV = 1'b0;
        edges = 0;
        lastClk = SPI_Clk;
        for (int i = 0; i < TIMEOUT && edges < 7; i++) begin
            @(posedge clk);
            #1;
            if (SPI_Clk !== lastClk) begin
                edges++;
                lastClk = SPI_Clk;
            end
        end
        checkOutput("edge7_reached", 32'(edges), 32'd7);
        checkOutput("cs_low_before_reset", 32'(SPI_CS_n), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("abort_cs_n", 32'(SPI_CS_n), 32'd1);
        checkOutput("abort_sclk", 32'(SPI_Clk), 32'd0);
        checkOutput("abort_tx_ready", 32'(TX_Ready), 32'd1);
        checkOutput("abort_rx_count", 32'(RX_Count), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        curCpol = 1'b0;
        curCpha = 1'b0;
        misoBits.delete();
        monOn = 1;

        // A fresh single-byte frame after the abort.
        txBuf[0] = 8'h96; rplBuf[0] = 8'h69;
        applyStimulus(1, 1'b0, 1'b0);

        // Randomised frames.
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < MAXB; k++) begin
                txBuf[k]  = 8'($urandom);
                rplBuf[k] = 8'($urandom);
            end
            applyStimulus($urandom_range(0, 15), 1'($urandom), 1'($urandom));
        end

        waitReady(ok);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rx_queue_drained", 32'(rxQ.size()), 32'd0);
        checkOutput("mosi_queue_drained", 32'(mosiQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_master_cs.md
Name: spi_master_cs

Overview:
- SPI master with a single chip-select. It serialises command/address/data bytes to the ADXL362 accelerometer and returns each received byte.
- Sits directly downstream of the accelerometer communication sequencer, which is the only source of TX_DV/TX_Byte/TX_Count/CPOL/CPHA.
- Sits directly upstream of the same sequencer for TX_Ready/RX_DV/RX_Byte/RX_Count.
- Holds CS low for TX_Count bytes per transaction, then enforces a CS-high gap before accepting the next transaction.

Parameters:
- CLKS_PER_HALF_BIT, 10, clk cycles per SPI_Clk half period (100 MHz gives 5 MHz SCLK; ADXL362 limit is 8 MHz); must be ≥2.
- CS_INACTIVE_CLKS, 10, minimum clk cycles CS_n stays high between transactions.
- MAX_BYTES_PER_CS, 8, maximum bytes per CS-low frame; must equal the sequencer's value.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- TX_Count  in  $clog2(MAX_BYTES_PER_CS+1)  bytes in this frame; sampled only with the first TX_DV of a frame
- TX_Byte  in  8  byte to transmit, MSB first
- TX_DV  in  1  one-cycle strobe; accepted only while TX_Ready=1
- CPOL  in  1  clock polarity; sampled with the first TX_DV of a frame
- CPHA  in  1  clock phase; sampled with the first TX_DV of a frame
- TX_Ready  out  1  master can accept TX_DV
- RX_DV  out  1  one-cycle pulse: RX_Byte valid
- RX_Byte  out  8  last received byte
- RX_Count  out  $clog2(MAX_BYTES_PER_CS+1)  bytes received in the current/last frame
- SPI_Clk  out  1  serial clock
- SPI_MOSI  out  1  serial data out
- SPI_MISO  in  1  serial data in
- SPI_CS_n  out  1  chip select, active low

Behaviour:
- Reset values: TX_Ready=1, RX_DV=0, RX_Byte=0, RX_Count=0, SPI_Clk=0, SPI_MOSI=0, SPI_CS_n=1.
- All outputs are registered.
- Reset mid-transfer aborts the frame immediately (asynchronous): CS_n=1.

FSM states: IDLE, SHIFT, WAIT_BYTE, CS_HOLD, CS_INACTIVE.
- IDLE: TX_Ready=1, CS_n=1, SPI_Clk=CPOL of the last frame (0 after reset).
  - On TX_DV, latch TX_Byte, CPOL, CPHA and the byte count.
  - Count rule: 0 is treated as 1; a value above MAX_BYTES_PER_CS is clamped to MAX_BYTES_PER_CS.
  - Next cycle: CS_n=0, RX_Count=0, TX_Ready=0, SPI_Clk=CPOL, go to SHIFT.
- SHIFT: generate 16 SPI_Clk edges, one every CLKS_PER_HALF_BIT cycles. The first edge comes CLKS_PER_HALF_BIT cycles after entry.
  - CPHA=0: MOSI = bit7 on entry; sample MISO on leading edges; update MOSI on trailing edges.
  - CPHA=1: update MOSI on leading edges; sample MISO on trailing edges.
  - Byte time is exactly 16*CLKS_PER_HALF_BIT cycles.
- Byte completion, in the cycle after the 16th edge:
  - RX_Byte updated, RX_DV=1 for one cycle, RX_Count+1 in the same cycle.
  - If bytes remain, go to WAIT_BYTE with TX_Ready=1 in that same cycle.
  - Otherwise go to CS_HOLD.
- WAIT_BYTE: CS_n stays low, SPI_Clk=CPOL.
  - On TX_Byte with TX_DV, load it, TX_Ready=0, re-enter SHIFT.
  - No timeout; CS remains low indefinitely.
- CS_HOLD: one cycle, CS_n still low (hold time). Then CS_n=1 and go to CS_INACTIVE.
- CS_INACTIVE: count CS_INACTIVE_CLKS cycles with TX_Ready=0, then go to IDLE with TX_Ready=1.
- TX_DV while TX_Ready=0 is ignored; no queuing, no error flag.
- RX_Count holds its final value (e.g. 8) through CS_INACTIVE and IDLE. It clears only when the next frame starts.
  - This lets the sequencer detect frame end without TX_Ready.
- A TX_DV in the same cycle TX_Ready rises is accepted.
- RX_DV and TX_Ready can be high together.

Optional Feature:
- Macro SPI_MASTER_LOOPBACK_EN.
- Defined: the MISO sampler takes the internal MOSI register instead of SPI_MISO. Each RX_Byte equals the TX_Byte of the same slot. The SPI_MISO pin is ignored.
- Undefined: normal operation, and no loopback logic is synthesised.

Decomposition:
- Package spi_pkg:
  - state enum spi_state_t {IDLE, SHIFT, WAIT_BYTE, CS_HOLD, CS_INACTIVE}
  - constant BITS_PER_BYTE=8
  - constant EDGES_PER_BYTE=16
  - typedef for the SPI mode {CPOL,CPHA}
- Sub-module spi_clk_gen:
  - Inputs: enable, CPOL, CLKS_PER_HALF_BIT counter.
  - Outputs: SPI_Clk, leading_edge and trailing_edge one-cycle pulses, edges_done.
  - The top FSM drives shifting and CS.

Test Plan:
- Mode 0, CLKS_PER_HALF_BIT=2, write frame TX_Count=3 of 0x0A,0x2D,0x02, each sent on TX_Ready -> MOSI bit stream 0000_1010 0010_1101 0000_0010.
  - CS_n low for the whole frame.
  - RX_DV pulses 3 times; RX_Count steps 1,2,3 and holds 3.
  - TX_Ready low for CS_INACTIVE_CLKS after CS_n rises.
- Read frame TX_Count=8, bytes 0x0B,0x0E then six 0x00; slave model returns 0x00,0x00,0x11,0x22,0x33,0x44,0x55,0x66 -> RX_Byte sequence matches, RX_Count=8 held in IDLE, and clears to 0 on the next TX_DV.
- CPOL=1, CPHA=1, single byte 0xA5, MISO returns 0x3C -> SPI_Clk idles high and MOSI changes on falling edges. RX_Byte=0x3C, byte time 16*CLKS_PER_HALF_BIT cycles.
- TX_DV pulsed during SHIFT and during CS_INACTIVE -> ignored; MOSI stream and RX_Count unchanged.
- Assert rst at the 7th SPI_Clk edge of byte 2 -> same cycle CS_n=1, SPI_Clk=0, TX_Ready=1, RX_Count=0; a new 1-byte frame afterwards completes normally.
- With SPI_MASTER_LOOPBACK_EN, TX_Count=2, bytes 0x5A,0xC3 -> RX_Byte 0x5A then 0xC3, SPI_MISO held at 1 has no effect.
